if_fetch_stage: RTL

- Instruction-fetch stage between the program counter register and the decode stage.
- Issues one instruction-memory request per PC value and tolerates variable memory latency.
- Captures the returned word into the IF/ID pipeline register and drives the PC pause input, so the PC advances only once its instruction has been accepted.
- Handles decode-side stalls through a one-entry hold buffer, and branch flushes through a discard state.

---
 rtl/if_fetch_stage.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/if_fetch_stage.sv
// ----------------------------------------------------------------------------
// if_fetch_stage
//
// Instruction-fetch stage sitting between the PC register and decode.
// Issues one instruction-memory request per PC value, tolerates any memory
// latency, and captures the returned word into the IF/ID pipeline register.
// o_pause_pc gates the PC so it only advances once its instruction has been
// accepted (or squashed).
//
// A one-entry hold buffer absorbs a response that arrives while decode is
// stalled. A discard state drains a response that was outstanding when a
// flush arrived.
//
// Ports:
//   clk             rising-edge clock
//   rst             synchronous, active-low reset
//   i_pc_in         current PC register output (address to fetch)
//   o_pause_pc      1 holds the PC, 0 lets it load its next value
//   o_imem_req      instruction-memory request valid
//   o_imem_addr     request address, stable until accepted
//   i_imem_ready    memory response strobe (rdata valid same cycle)
//   i_imem_rdata    fetched instruction word
//   i_stall_id      decode cannot accept; IF/ID must hold
//   i_flush         branch/jump redirect; squash current fetch and IF/ID
//   o_if_id_valid   IF/ID holds a real instruction
//   o_if_id_pc      PC of the IF/ID instruction
//   o_if_id_instr   IF/ID instruction word
// ----------------------------------------------------------------------------
module if_fetch_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_pc_in,
  output logic        o_pause_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_ready,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall_id,
  input  logic        i_flush,
  output logic        o_if_id_valid,
  output logic [31:0] o_if_id_pc,
  output logic [31:0] o_if_id_instr
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DROP  = 2'd2
  } state_t;

  state_t      r_state;
  logic [31:0] r_req_addr;
  logic [31:0] r_hold_pc;
  logic [31:0] r_hold_instr;
  logic        r_if_id_valid;
  logic [31:0] r_if_id_pc;
  logic [31:0] r_if_id_instr;

  assign o_if_id_valid = r_if_id_valid;
  assign o_if_id_pc    = r_if_id_pc;
  assign o_if_id_instr = r_if_id_instr;

  // Memory request and PC gating, decoded from the current state and inputs.
  // These must react within the cycle so a zero-wait memory sustains one
  // instruction per clock.
  always_comb begin
    o_imem_req  = 1'b0;
    o_imem_addr = i_pc_in;
    o_pause_pc  = 1'b1;
    if (!rst) begin
      // Reset abandons any outstanding request and freezes the PC.
      o_imem_req = 1'b0;
      o_pause_pc = 1'b1;
    end else begin
      case (r_state)
        S_FETCH: begin
          o_imem_req  = 1'b1;
          o_imem_addr = i_pc_in;
          // The PC advances on any completed or squashed fetch.
          if (i_flush || i_imem_ready) begin
            o_pause_pc = 1'b0;
          end else begin
            o_pause_pc = 1'b1;
          end
        end
        S_HOLD: begin
          // PC already advanced when the held word arrived; only a flush
          // may load the branch target here.
          o_imem_req = 1'b0;
          if (i_flush) begin
            o_pause_pc = 1'b0;
          end else begin
            o_pause_pc = 1'b1;
          end
        end
        S_DROP: begin
          // Keep presenting the squashed address until memory responds.
          o_imem_req  = 1'b1;
          o_imem_addr = r_req_addr;
          if (i_flush) begin
            o_pause_pc = 1'b0;
          end else begin
            o_pause_pc = 1'b1;
          end
        end
        default: begin
          o_imem_req = 1'b0;
          o_pause_pc = 1'b1;
        end
      endcase
    end
  end

  // Fetch state machine, hold buffer and IF/ID pipeline register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state       <= S_FETCH;
      r_req_addr    <= 32'h0000_0000;
      r_hold_pc     <= 32'h0000_0000;
      r_hold_instr  <= 32'h0000_0000;
      r_if_id_valid <= 1'b0;
      r_if_id_pc    <= RESET_PC;
      r_if_id_instr <= NOP_INSTR;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (i_flush) begin
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= NOP_INSTR;
            if (!i_imem_ready) begin
              // Request still in flight: remember its address and drain it.
              r_req_addr <= i_pc_in;
              r_state    <= S_DROP;
            end else begin
              r_state <= S_FETCH;
            end
          end else if (i_imem_ready) begin
            if (!i_stall_id) begin
              r_if_id_valid <= 1'b1;
              r_if_id_pc    <= i_pc_in;
              r_if_id_instr <= i_imem_rdata;
            end else begin
              // Decode is busy: park the word, IF/ID keeps its content.
              r_hold_pc    <= i_pc_in;
              r_hold_instr <= i_imem_rdata;
              r_state      <= S_HOLD;
            end
          end else begin
            if (!i_stall_id) begin
              // Waiting on memory: send a bubble downstream.
              r_if_id_valid <= 1'b0;
              r_if_id_instr <= NOP_INSTR;
            end else begin
              r_if_id_valid <= r_if_id_valid;
            end
          end
        end
        S_HOLD: begin
          if (i_flush) begin
            r_if_id_valid <= 1'b0;
            r_if_id_instr <= NOP_INSTR;
            r_state       <= S_FETCH;
          end else if (!i_stall_id) begin
            r_if_id_valid <= 1'b1;
            r_if_id_pc    <= r_hold_pc;
            r_if_id_instr <= r_hold_instr;
            r_state       <= S_FETCH;
          end else begin
            r_state <= S_HOLD;
          end
        end
        S_DROP: begin
          r_if_id_valid <= 1'b0;
          r_if_id_instr <= NOP_INSTR;
          if (i_flush) begin
            r_state <= S_DROP;
          end else if (i_imem_ready) begin
            // Squashed response discarded; fetch the new PC next cycle.
            r_state <= S_FETCH;
          end else begin
            r_state <= S_DROP;
          end
        end
        default: begin
          r_state       <= S_FETCH;
          r_if_id_valid <= 1'b0;
          r_if_id_instr <= NOP_INSTR;
        end
      endcase
    end
  end

endmodule
